// File: rtl/frame_store_writer.sv
// frame_store_writer: buffers incoming pixel words in a small synchronous FIFO
// and issues single-word SDRAM write requests into a ring of frame slots.
// Tracks words per frame, reports completed frames and flags short frames
// and excess words.

module frame_store_writer #(
    parameter int          DATA_W          = 128,
    parameter int          ADDR_W          = 25,
    parameter int          DEPTH           = 16,
    parameter int          NUM_SLOTS       = 6,
    parameter int unsigned SLOT_STRIDE     = 32'h0002_5800,
    parameter int          WORDS_PER_FRAME = 38400,
    parameter int unsigned ADDR_INC        = 4,
    localparam int         SW              = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    localparam int         LW              = $clog2(DEPTH) + 1
) (
    input  logic              clk_133M,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              ram_busy,
    output logic              wr_req,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] wr_address,
    output logic [SW-1:0]     slot,
    output logic [SW-1:0]     last_slot,
    output logic              last_valid,
    output logic              frame_done,
    output logic              frame_error,
    output logic [LW-1:0]     level
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(WORDS_PER_FRAME + 1);

    localparam logic [ADDR_W-1:0] STRIDE_C = ADDR_W'(SLOT_STRIDE);
    localparam logic [ADDR_W-1:0] INC_C    = ADDR_W'(ADDR_INC);
    localparam logic [CW-1:0]     WPF_C    = CW'(WORDS_PER_FRAME);
    localparam logic [CW-1:0]     LAST_C   = CW'(WORDS_PER_FRAME - 1);
    localparam logic [LW-1:0]     FULL_C   = LW'(DEPTH);
    localparam logic [SW-1:0]     TOP_C    = SW'(NUM_SLOTS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wrPtr_q, rdPtr_q;
    logic [PW-1:0]     wrIdx;
    logic [LW-1:0]     count_q;

    logic              started_q;
    logic [SW-1:0]     slot_q, lastSlot_q, nextSlot;
    logic [ADDR_W-1:0] base_q, addr_q, nextBase;
    logic [CW-1:0]     wordCnt_q;

    logic              wrReq_q, frameDone_q, frameError_q, lastValid_q;
    logic [DATA_W-1:0] data_q;

    logic fifoEmpty, fifoFull, inReady, push, pop;
    logic frameOpen, issue, discard, finalWord, shortFrame;

    // State register: a new frame always reopens writing, reset returns to idle.
    always_ff @(posedge clk_133M or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: frame_start wins over everything, the final issued word closes the frame.
    always_comb begin
        state_d = state_q;
        if (frame_start) begin
            state_d = ACTIVE;
        end else if (finalWord) begin
            state_d = DONE;
        end
    end

    // Control decode: handshake, write issue, excess-word drain and short-frame detect.
    always_comb begin
        fifoEmpty  = (count_q == '0);
        fifoFull   = (count_q == FULL_C);
        inReady    = (state_q != IDLE) && !fifoFull;
        push       = in_valid && inReady;
        frameOpen  = (wordCnt_q < WPF_C);
        issue      = (state_q == ACTIVE) && !fifoEmpty && !ram_busy && !wrReq_q
                     && frameOpen && !frame_start;
        discard    = (state_q == DONE) && !fifoEmpty && !frame_start;
        pop        = issue || discard;
        finalWord  = issue && (wordCnt_q == LAST_C);
        shortFrame = frame_start && (state_q == ACTIVE) && frameOpen;
        wrIdx      = frame_start ? '0 : wrPtr_q;
    end

    // Next slot and base: the first frame after reset lands in slot 0, then the ring
    // advances by one stride and wraps back to slot 0 without any multiplication.
    always_comb begin
        nextSlot = '0;
        nextBase = '0;
        if (started_q && (slot_q != TOP_C)) begin
            nextSlot = slot_q + SW'(1);
            nextBase = base_q + STRIDE_C;
        end
    end

    // FIFO storage: a word arriving with frame_start becomes entry 0 of the flushed FIFO.
    always_ff @(posedge clk_133M) begin
        if (push) begin
            mem_q[wrIdx] <= in_data;
        end
    end

    // FIFO pointers and occupancy, flushed by frame_start.
    always_ff @(posedge clk_133M or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else if (frame_start) begin
            rdPtr_q <= '0;
            wrPtr_q <= push ? PW'(1) : '0;
            count_q <= push ? LW'(1) : '0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + PW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            count_q <= count_q + LW'(push) - LW'(pop);
        end
    end

    // Frame tracking: slot ring, running write address and words issued this frame.
    always_ff @(posedge clk_133M or posedge rst) begin
        if (rst) begin
            started_q <= 1'b0;
            slot_q    <= '0;
            base_q    <= '0;
            addr_q    <= '0;
            wordCnt_q <= '0;
        end else if (frame_start) begin
            started_q <= 1'b1;
            slot_q    <= nextSlot;
            base_q    <= nextBase;
            addr_q    <= nextBase;
            wordCnt_q <= '0;
        end else begin
            if (issue) begin
                wordCnt_q <= wordCnt_q + CW'(1);
            end
            if (wrReq_q) begin
                addr_q <= addr_q + INC_C;
            end
        end
    end

    // Request and status registers: write strobe, data, completion and error pulses.
    always_ff @(posedge clk_133M or posedge rst) begin
        if (rst) begin
            wrReq_q      <= 1'b0;
            data_q       <= '0;
            frameDone_q  <= 1'b0;
            frameError_q <= 1'b0;
            lastSlot_q   <= '0;
            lastValid_q  <= 1'b0;
        end else begin
            wrReq_q      <= issue;
            frameDone_q  <= finalWord;
            frameError_q <= shortFrame || discard;
            if (issue) begin
                data_q <= mem_q[rdPtr_q];
            end
            if (finalWord) begin
                lastSlot_q  <= slot_q;
                lastValid_q <= 1'b1;
            end
        end
    end

    assign in_ready    = inReady;
    assign wr_req      = wrReq_q;
    assign data        = data_q;
    assign wr_address  = addr_q;
    assign slot        = slot_q;
    assign last_slot   = lastSlot_q;
    assign last_valid  = lastValid_q;
    assign frame_done  = frameDone_q;
    assign frame_error = frameError_q;
    assign level       = count_q;

endmodule

// File: tb/tb_frame_store_writer.sv
// Testbench for frame_store_writer: directed frames against a small
// event-level model of where every written word must land.

module tb_frame_store_writer;

    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 25;
    localparam int DEPTH       = 4;
    localparam int NUM_SLOTS   = 3;
    localparam int SLOT_STRIDE = 16;
    localparam int WPF         = 4;
    localparam int ADDR_INC    = 4;

    logic              clk_133M = 1'b0;
    logic              rst;
    logic              frame_start;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              ram_busy;
    logic              wr_req;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] wr_address;
    logic [1:0]        slot;
    logic [1:0]        last_slot;
    logic              last_valid;
    logic              frame_done;
    logic              frame_error;
    logic [2:0]        level;

    logic holdBusy;
    logic wrReqSeen;

    int checkCount = 0;
    int passCount  = 0;
    int cycleNo    = 0;

    int          frameCount;
    int          slotModel;
    int          writes;
    int          lastSlotModel;
    bit          lastValidModel;
    bit          shortPending;
    int          expAddr;
    logic [31:0] accQ[$];

    int          addrLog[$];
    logic [31:0] dataLog[$];
    int          wrCycleLog[$];
    int          acceptCycleLog[$];
    int          doneCount;
    int          errPulses;

    int expSlots[4] = '{0, 1, 2, 0};
    int expBases[4] = '{0, 16, 32, 0};

    frame_store_writer #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH(DEPTH),
        .NUM_SLOTS(NUM_SLOTS),
        .SLOT_STRIDE(SLOT_STRIDE),
        .WORDS_PER_FRAME(WPF),
        .ADDR_INC(ADDR_INC)
    ) dut (
        .clk_133M(clk_133M),
        .rst(rst),
        .frame_start(frame_start),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .ram_busy(ram_busy),
        .wr_req(wr_req),
        .data(data),
        .wr_address(wr_address),
        .slot(slot),
        .last_slot(last_slot),
        .last_valid(last_valid),
        .frame_done(frame_done),
        .frame_error(frame_error),
        .level(level)
    );

    // 133 MHz-ish clock; exact period is irrelevant to the design.
    always #5 clk_133M = ~clk_133M;

    // RAM controller stand-in: busy the cycle after it samples a request, or when held.
    always @(posedge clk_133M or posedge rst) begin
        if (rst) wrReqSeen <= 1'b0;
        else     wrReqSeen <= wr_req;
    end
    assign ram_busy = holdBusy | wrReqSeen;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: actual=%0h required=%0h at t=%0t", name, actual, expected, $time);
    endtask

    // Per-cycle compare against the model: every write lands at slot*stride + index*inc
    // with the index-th word accepted in that frame; completion and errors follow the frame rules.
    always @(negedge clk_133M) begin
        if (rst) begin
            frameCount     = 0;
            slotModel      = 0;
            writes         = 0;
            lastSlotModel  = 0;
            lastValidModel = 0;
            shortPending   = 0;
            accQ.delete();
        end else begin
            cycleNo++;
            if (wr_req) begin
                if (frameCount == 0 || writes >= WPF) begin
                    checkOutput("wr_req_outside_frame", 64'(writes), 64'(WPF - 1));
                end else begin
                    expAddr = slotModel * SLOT_STRIDE + writes * ADDR_INC;
                    checkOutput("wr_address", 64'(wr_address), 64'(expAddr));
                    if (writes < accQ.size()) checkOutput("data", 64'(data), 64'(accQ[writes]));
                    else checkOutput("data_source_depth", 64'(accQ.size()), 64'(writes + 1));
                    checkOutput("frame_done_on_req", 64'(frame_done), 64'(writes == WPF - 1));
                    addrLog.push_back(int'(wr_address));
                    dataLog.push_back(data);
                    wrCycleLog.push_back(cycleNo);
                    writes++;
                    if (writes == WPF) begin
                        lastSlotModel  = slotModel;
                        lastValidModel = 1;
                    end
                end
            end else begin
                checkOutput("frame_done_idle", 64'(frame_done), 64'(0));
            end
            if (frame_done) doneCount++;
            if (shortPending) begin
                checkOutput("frame_error_short", 64'(frame_error), 64'(1));
            end else if (frame_error) begin
                checkOutput("frame_error_excess_only_after_done", 64'(writes == WPF), 64'(1));
            end
            if (frame_error) errPulses++;
            checkOutput("slot", 64'(slot), 64'(slotModel));
            checkOutput("last_slot", 64'(last_slot), 64'(lastSlotModel));
            checkOutput("last_valid", 64'(last_valid), 64'(lastValidModel));

            shortPending = frame_start && (frameCount > 0) && (writes < WPF);
            if (frame_start) begin
                frameCount++;
                slotModel = (frameCount - 1) % NUM_SLOTS;
                writes    = 0;
                accQ.delete();
            end
            if (in_valid && in_ready) begin
                accQ.push_back(in_data);
                acceptCycleLog.push_back(cycleNo);
            end
        end
    end

    // Drive one cycle of frame_start/valid/data, then release them.
    task automatic applyStimulus(input logic fs, input logic v, input logic [31:0] d);
        frame_start = fs;
        in_valid    = v;
        in_data     = d;
        @(posedge clk_133M); #1;
        frame_start = 1'b0;
        in_valid    = 1'b0;
    endtask

    task automatic pulseStart();
        applyStimulus(1'b1, 1'b0, 32'h0);
    endtask

    // Offer one word and hold it until accepted, within a cycle budget.
    task automatic sendWord(input logic [31:0] d);
        bit acc = 0;
        int n   = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!acc && n < 50) begin
            @(negedge clk_133M);
            acc = in_ready;
            @(posedge clk_133M); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) checkOutput("in_ready_timeout", 64'(in_ready), 64'(1));
    endtask

    // Wait for the FIFO and request pipeline to empty, within a cycle budget.
    task automatic waitDrain();
        int n = 0;
        while (!(level == 0 && wr_req == 0 && frame_error == 0) && n < 200) begin
            @(posedge clk_133M); #1;
            n++;
        end
        checkOutput("drain_level", 64'(level), 64'(0));
        repeat (3) begin
            @(posedge clk_133M); #1;
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk_133M); #1;
        end
    endtask

    task automatic clearLogs();
        addrLog.delete();
        dataLog.delete();
        wrCycleLog.delete();
        acceptCycleLog.delete();
        doneCount = 0;
        errPulses = 0;
    endtask

    task automatic checkAddrAt(input string name, input int idx, input int exp);
        if (idx < addrLog.size()) checkOutput(name, 64'(addrLog[idx]), 64'(exp));
        else checkOutput({name, "_missing"}, 64'(addrLog.size()), 64'(idx + 1));
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_wr_req"}, 64'(wr_req), 64'(0));
        checkOutput({tag, "_data"}, 64'(data), 64'(0));
        checkOutput({tag, "_wr_address"}, 64'(wr_address), 64'(0));
        checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'(0));
        checkOutput({tag, "_slot"}, 64'(slot), 64'(0));
        checkOutput({tag, "_last_slot"}, 64'(last_slot), 64'(0));
        checkOutput({tag, "_last_valid"}, 64'(last_valid), 64'(0));
        checkOutput({tag, "_frame_done"}, 64'(frame_done), 64'(0));
        checkOutput({tag, "_frame_error"}, 64'(frame_error), 64'(0));
        checkOutput({tag, "_level"}, 64'(level), 64'(0));
    endtask

    task automatic doReset();
        rst         = 1'b1;
        holdBusy    = 1'b0;
        frame_start = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        idleCycles(2);
        rst = 1'b0;
        idleCycles(1);
        clearLogs();
    endtask

    // Directed scenarios with hand-computed expectations.
    initial begin
        rst = 1'b1;
        doReset();
        checkResetOutputs("reset");

        // Single frame: four writes at 0,4,8,12, done with the fourth.
        pulseStart();
        for (int k = 0; k < 4; k++) sendWord(32'hA000_0000 + k);
        waitDrain();
        checkOutput("single_count", 64'(addrLog.size()), 64'(4));
        for (int k = 0; k < 4; k++) checkAddrAt("single_addr", k, 4 * k);
        if (dataLog.size() == 4) checkOutput("single_data3", 64'(dataLog[3]), 64'(32'hA000_0003));
        checkOutput("single_done_count", 64'(doneCount), 64'(1));
        checkOutput("single_last_slot", 64'(last_slot), 64'(0));
        checkOutput("single_last_valid", 64'(last_valid), 64'(1));
        if (wrCycleLog.size() > 0 && acceptCycleLog.size() > 0)
            checkOutput("single_latency", 64'(wrCycleLog[0] - acceptCycleLog[0]), 64'(2));

        // Ring wrap: four frames land at bases 0,16,32,0 in slots 0,1,2,0.
        doReset();
        for (int f = 0; f < 4; f++) begin
            pulseStart();
            checkOutput("ring_slot", 64'(slot), 64'(expSlots[f]));
            for (int k = 0; k < 4; k++) sendWord(32'hB000_0000 + 32'(f * 16 + k));
            waitDrain();
            checkAddrAt("ring_base", 4 * f, expBases[f]);
        end
        checkOutput("ring_done_count", 64'(doneCount), 64'(4));
        checkOutput("ring_last_slot", 64'(last_slot), 64'(0));

        // Backpressure: busy held for 10 cycles with the FIFO full.
        doReset();
        holdBusy = 1'b1;
        pulseStart();
        for (int k = 0; k < 4; k++) sendWord(32'hC000_0000 + k);
        idleCycles(5);
        checkOutput("bp_no_writes", 64'(addrLog.size()), 64'(0));
        checkOutput("bp_level", 64'(level), 64'(4));
        checkOutput("bp_in_ready", 64'(in_ready), 64'(0));
        holdBusy = 1'b0;
        waitDrain();
        checkOutput("bp_count", 64'(addrLog.size()), 64'(4));
        for (int k = 0; k < 4; k++) checkAddrAt("bp_addr", k, 4 * k);
        for (int k = 1; k < wrCycleLog.size(); k++)
            checkOutput("bp_spacing", 64'((wrCycleLog[k] - wrCycleLog[k-1]) >= 2), 64'(1));

        // Short frame: two writes, one queued word, then a new frame.
        doReset();
        pulseStart();
        for (int k = 0; k < 2; k++) sendWord(32'hD000_0000 + k);
        waitDrain();
        holdBusy = 1'b1;
        sendWord(32'hD000_00FF);
        checkOutput("short_level_before", 64'(level), 64'(1));
        pulseStart();
        checkOutput("short_level_flushed", 64'(level), 64'(0));
        holdBusy = 1'b0;
        idleCycles(3);
        checkOutput("short_error_count", 64'(errPulses), 64'(1));
        checkOutput("short_last_valid", 64'(last_valid), 64'(0));
        checkOutput("short_writes", 64'(addrLog.size()), 64'(2));
        for (int k = 0; k < 4; k++) sendWord(32'hD100_0000 + k);
        waitDrain();
        checkAddrAt("short_next_first", 2, 16);
        checkAddrAt("short_next_last", 5, 28);
        checkOutput("short_next_last_slot", 64'(last_slot), 64'(1));

        // Excess words: six words, four writes, two error pulses.
        doReset();
        pulseStart();
        for (int k = 0; k < 6; k++) sendWord(32'hE000_0000 + k);
        waitDrain();
        idleCycles(5);
        checkOutput("excess_writes", 64'(addrLog.size()), 64'(4));
        checkOutput("excess_done_count", 64'(doneCount), 64'(1));
        checkOutput("excess_error_count", 64'(errPulses), 64'(2));

        // Asynchronous reset mid-frame, then a fresh frame from slot 0.
        doReset();
        pulseStart();
        for (int k = 0; k < 4; k++) sendWord(32'hF000_0000 + k);
        waitDrain();
        pulseStart();
        for (int k = 0; k < 2; k++) sendWord(32'hF100_0000 + k);
        waitDrain();
        checkOutput("async_pre_slot", 64'(slot), 64'(1));
        holdBusy = 1'b1;
        sendWord(32'hF100_00FF);
        @(posedge clk_133M); #2;
        rst = 1'b1;
        #1;
        checkResetOutputs("async");
        @(posedge clk_133M); #1;
        rst      = 1'b0;
        holdBusy = 1'b0;
        clearLogs();
        pulseStart();
        for (int k = 0; k < 4; k++) sendWord(32'hF200_0000 + k);
        waitDrain();
        checkAddrAt("async_first", 0, 0);
        checkAddrAt("async_last", 3, 12);
        checkOutput("async_last_slot", 64'(last_slot), 64'(0));
        checkOutput("async_last_valid", 64'(last_valid), 64'(1));

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/frame_store_writer.md
# frame_store_writer

Parametrised frame-buffer write engine for the SDRAM write path, sitting after the camera clock-domain crossing in the 133 MHz domain. It buffers incoming pixel words in an internal synchronous FIFO and issues single-word write requests to the RAM controller, honouring `ram_busy`. Frames go to a ring of `NUM_SLOTS` buffers, with per-frame word counting, completion reporting and short/long-frame error detection.

## Interface
- `DATA_W`, 128: data word width.
- `ADDR_W`, 25: RAM address width.
- `DEPTH`, 16: FIFO depth in words; power of two, ≥4.
- `NUM_SLOTS`, 6: number of frame slots in the ring; ≥2.
- `SLOT_STRIDE`, 25'h25800: address distance between slot bases.
- `WORDS_PER_FRAME`, 38400: words per complete frame.
- `ADDR_INC`, 4: address increment per word.
- `SW`, derived: max(1, ceil(log2(NUM_SLOTS))). `LW`, derived: log2(DEPTH)+1.

Ports:
- `clk_133M`  in  1: single clock.
- `rst`  in  1: asynchronous, active-high reset.
- `frame_start`  in  1: one-cycle pulse; the next frame begins.
- `in_data`  in  DATA_W: input word.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: the block accepts a word this cycle.
- `ram_busy`  in  1: RAM controller cannot take a request.
- `wr_req`  out  1: one-cycle write request.
- `data`  out  DATA_W: write data; valid while `wr_req`=1.
- `wr_address`  out  ADDR_W: write address; valid while `wr_req`=1.
- `slot`  out  SW: slot currently being written.
- `last_slot`  out  SW: most recently completed slot.
- `last_valid`  out  1: `last_slot` holds a completed frame.
- `frame_done`  out  1: one-cycle pulse when a frame completes.
- `frame_error`  out  1: one-cycle pulse on a short-frame or excess-word event.
- `level`  out  LW: FIFO occupancy.

## Operation
- **States:**
  - IDLE: entered at reset. `in_ready`=0.
  - ACTIVE: writing the current slot.
  - DONE: frame complete; excess words are drained.
- **`frame_start` handling (any state):**
  - The FIFO is flushed.
  - `word_cnt` is cleared.
  - The state goes to ACTIVE.
  - `slot` advances: the first `frame_start` after reset selects slot 0; after that, slot = (slot == NUM_SLOTS-1) ? 0 : slot+1.
  - `wr_address` is set to slot×SLOT_STRIDE. The base is maintained incrementally by adding SLOT_STRIDE, with no multiplier; it wraps to 0 together with `slot`.
  - Short frame: if the state was ACTIVE with word_cnt < WORDS_PER_FRAME, `frame_error` pulses.
- **`in_ready`** = (state ≠ IDLE) && FIFO not full. A word is pushed when `in_valid` && `in_ready`.
  - A word accepted in the same cycle as `frame_start` is stored after the flush and becomes word 0 of the new frame.
- **Issue condition (ACTIVE):** FIFO not empty && `ram_busy`=0 && `wr_req`=0 && word_cnt < WORDS_PER_FRAME.
  - On issue: pop the FIFO, register `data` and `wr_address`, and set `wr_req`=1 the next cycle.
  - After the request, `wr_address` += ADDR_INC and `word_cnt` += 1.
  - The controller raises `ram_busy` in the cycle after it samples `wr_req`. This allows at most one request every two cycles.
- **Frame completion:** when the issued word makes word_cnt == WORDS_PER_FRAME:
  - `frame_done` pulses in the same cycle as that final `wr_req`.
  - `last_slot` is set to `slot` and `last_valid` to 1.
  - The state goes to DONE.
- **DONE:** FIFO words are popped one per cycle and discarded; no `wr_req`. Each discarded word pulses `frame_error`.
- **Flush precedence:** if `frame_start` coincides with an issue decision, the issue is suppressed and the flush wins.
  - A `wr_req` already registered still completes.
  - If that `wr_req` is the final word, `frame_done` is reported and there is no short-frame error.
- **Widths:** address arithmetic is modulo 2^ADDR_W. `word_cnt` is ceil(log2(WORDS_PER_FRAME+1)) bits.

## Timing
- **Reset values:** every output is 0 (`wr_req`, `data`, `wr_address`, `in_ready`, `slot`, `last_slot`, `last_valid`, `frame_done`, `frame_error`, `level`). Internal state is IDLE.
- **Latency:** a word pushed at cycle t with the RAM idle gives `wr_req` at t+2.
- `level` is registered and reflects pushes and pops of the previous cycle. The flush sets it to 0 (or to 1 if a word was pushed in the `frame_start` cycle).
- **Reset mid-frame:** all state is lost immediately (asynchronous). The next `frame_start` selects slot 0 again and `last_valid`=0.
- `frame_done` and `frame_error` never last longer than one cycle per event.

## Test plan
Parameters for all scenarios: NUM_SLOTS=3, WORDS_PER_FRAME=4, SLOT_STRIDE=16, ADDR_INC=4, DEPTH=4.
- **Single frame:** `frame_start`, then 4 words, `ram_busy`=0 → `wr_req` at addresses 0, 4, 8, 12 with matching data. `frame_done` with the 4th request; `last_slot`=0, `last_valid`=1.
- **Ring wrap:** 4 full frames → bases 0, 16, 32, 0. `slot` sequence 0, 1, 2, 0. `last_slot` ends at 0.
- **Backpressure:** hold `ram_busy`=1 for 10 cycles with 4 words queued → no `wr_req`; `level`=4, `in_ready`=0. On release, 4 requests in order, spaced ≥2 cycles.
- **Short frame:** 2 words written, then `frame_start` → `frame_error` pulse, FIFO flushed. The next frame starts at address 16; `last_valid` unchanged.
- **Excess words:** 6 words in one frame → 4 writes and `frame_done`, then 2 `frame_error` pulses, no further `wr_req`.
- **Async reset mid-frame:** assert `rst` after 2 writes → all outputs 0 immediately. The next frame writes at address 0.
